ram_sync_be: RTL and testbench

//  Parametrised single-clock RAM, successor to the plain async-read RAM: registered read

---
 rtl/ram_sync_be_pkg.sv | 19 +
 rtl/ram_init_seq.sv | 61 ++++++
 rtl/ram_sync_be.sv | 112 +++++++++++
 tb/tb_ram_sync_be.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_sync_be_pkg.sv
// ============================================================================
// Module      : ram_sync_be_pkg
// Description : Shared types for the ram_sync_be RAM slice. Holds the
//               CLEAR/READY state encoding used by the clear sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_sync_be_pkg;

    // Clear sequencer states: CLEAR fills the array, READY serves the user
    typedef enum logic [0:0] {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_state_e;

endpackage : ram_sync_be_pkg

`default_nettype wire

// File: rtl/ram_init_seq.sv
// ============================================================================
// Module      : ram_init_seq
// Description : Post-reset clear sequencer. Walks clear_addr across every
//               entry, one per cycle, then parks in READY. busy_o is high
//               for exactly DEPTH cycles after reset is released.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_init_seq
    import ram_sync_be_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy_o,
    output logic                  clear_we_o,
    output logic [DEPTH_LOG2-1:0] clear_addr_o
);

    localparam logic [DEPTH_LOG2-1:0] C_LAST_ADDR = {DEPTH_LOG2{1'b1}};

    ram_state_e            state_q;
    logic [DEPTH_LOG2-1:0] clear_ptr_q;
    logic                  busy_q;

    // Clear FSM: pointer advances each CLEAR cycle; leaves after the last entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RAM_ST_CLEAR;
            clear_ptr_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                RAM_ST_CLEAR: begin
                    clear_ptr_q <= clear_ptr_q + 1'b1;
                    if (clear_ptr_q == C_LAST_ADDR) begin
                        state_q <= RAM_ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                RAM_ST_READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= RAM_ST_CLEAR;
                    clear_ptr_q <= '0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign clear_we_o   = busy_q;
    assign clear_addr_o = clear_ptr_q;

endmodule : ram_init_seq

`default_nettype wire

// File: rtl/ram_sync_be.sv
// ============================================================================
// Module      : ram_sync_be
// Description : Single-clock RAM with per-lane write enables, registered
//               read port (req/valid, latency 1) and a post-reset clear
//               sequence that fills every entry with CLEAR_VALUE.
//               Build option RAM_BYPASS_EN: a read colliding with a write to
//               the same address returns the merged (write-first) word;
//               without it the old contents are returned (read-first).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_sync_be
    import ram_sync_be_pkg::*;
#(
    parameter  int                    DATA_WIDTH  = 8,
    parameter  int                    LANE_WIDTH  = 8,
    parameter  int                    DEPTH_LOG2  = 4,
    parameter  logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int                    LANES       = DATA_WIDTH / LANE_WIDTH,
    localparam int                    DEPTH       = 1 << DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DEPTH_LOG2-1:0] in_addr,
    input  logic [LANES-1:0]      in_be,
    input  logic                  in_latch,
    input  logic [DEPTH_LOG2-1:0] out_addr,
    input  logic                  out_req,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  busy_w;
    logic                  clear_we_w;
    logic [DEPTH_LOG2-1:0] clear_addr_w;
    logic                  user_we_w;
    logic                  rd_en_w;
    logic                  byp_hit_w;
    logic [DATA_WIDTH-1:0] mem_rd_w;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    ram_init_seq #(
        .DEPTH_LOG2   (DEPTH_LOG2)
    ) u_init_seq (
        .clk          (clk),
        .reset        (reset),
        .busy_o       (busy_w),
        .clear_we_o   (clear_we_w),
        .clear_addr_o (clear_addr_w)
    );

    // User traffic is dropped entirely while the clear sequence owns the array
    assign user_we_w = in_latch & ~busy_w & ~reset;
    assign rd_en_w   = out_req & ~busy_w;
    assign mem_rd_w  = mem_q[out_addr];

`ifdef RAM_BYPASS_EN
    assign byp_hit_w = user_we_w & (in_addr == out_addr);
`else
    assign byp_hit_w = 1'b0;
`endif

    // Per-lane read merge: enabled lanes of a colliding write are forwarded
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign out_data_d[g*LANE_WIDTH +: LANE_WIDTH] =
            (byp_hit_w && in_be[g]) ? in_data[g*LANE_WIDTH +: LANE_WIDTH]
                                    : mem_rd_w[g*LANE_WIDTH +: LANE_WIDTH];
    end

    // Array write: clear sequence has priority; user writes touch enabled lanes only
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clear_we_w) begin
                mem_q[clear_addr_w] <= CLEAR_VALUE;
            end else if (user_we_w) begin
                for (int i = 0; i < LANES; i++) begin
                    if (in_be[i]) begin
                        mem_q[in_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                            in_data[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // Registered read port: data updates only on an accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_en_w;
            if (rd_en_w) begin
                out_data_q <= out_data_d;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_w;

endmodule : ram_sync_be

`default_nettype wire

// File: tb/tb_ram_sync_be.sv
// ============================================================================
// Module      : tb_ram_sync_be
// Description : Directed self-checking bench for ram_sync_be
//               (16-bit words, 8-bit lanes, 16 entries, clear value A5A5).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_sync_be;

    localparam int          DW   = 16;
    localparam int          AW   = 4;
    localparam logic [15:0] CLRV = 16'hA5A5;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_be;
    logic          in_latch;
    logic [AW-1:0] out_addr;
    logic          out_req;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    ram_sync_be #(
        .DATA_WIDTH  (DW),
        .LANE_WIDTH  (8),
        .DEPTH_LOG2  (AW),
        .CLEAR_VALUE (CLRV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_be     (in_be),
        .in_latch  (in_latch),
        .out_addr  (out_addr),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_latch = 1'b0;
        out_req  = 1'b0;
        in_be    = 2'b00;
        in_data  = '0;
        in_addr  = '0;
        out_addr = '0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        in_latch = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_be    = be;
        tick();
        in_latch = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        out_req  = 1'b1;
        out_addr = a;
        tick();
        out_req  = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"},  32'(out_data),  32'(exp));
    endtask

    // Counts cycles that busy stays high, bounded so a stuck busy cannot hang
    task automatic count_busy(output int cnt, output int valid_seen);
        cnt        = 0;
        valid_seen = 0;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
            if (out_valid) valid_seen++;
        end
    endtask

    initial begin
        int cnt;
        int vseen;
        logic [DW-1:0] exp_collide;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_busy",  32'(busy),      32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);

        // Clear sequence length and contents
        reset = 1'b0;
        count_busy(cnt, vseen);
        check_eq("clear_len", 32'(cnt), 32'd16);
        for (int a = 0; a < 16; a++) read_chk("clr_rd", AW'(a), CLRV);
        tick();
        check_eq("idle_valid", 32'(out_valid), 32'd0);
        check_eq("idle_hold",  32'(out_data),  32'(CLRV));

        // Lane-enable merge
        write(4'd3, 16'h1234, 2'b11);
        write(4'd3, 16'hFFFF, 2'b01);
        read_chk("be_rd", 4'd3, 16'h12FF);
        tick();
        check_eq("be_valid_once", 32'(out_valid), 32'd0);
        check_eq("be_hold",       32'(out_data),  32'h12FF);

        // Fill data=addr, then back-to-back reads with no gaps
        for (int a = 0; a < 16; a++) write(AW'(a), DW'(a), 2'b11);
        out_req = 1'b1;
        for (int a = 0; a < 16; a++) begin
            out_addr = AW'(a);
            tick();
            check_eq("b2b_valid", 32'(out_valid), 32'd1);
            check_eq("b2b_data",  32'(out_data),  32'(a));
        end
        out_req = 1'b0;
        tick();
        check_eq("b2b_end_valid", 32'(out_valid), 32'd0);

        // Same-address collision
        write(4'd5, 16'h0011, 2'b11);
        in_latch = 1'b1; in_addr = 4'd5; in_data = 16'hBEEF; in_be = 2'b10;
        out_req  = 1'b1; out_addr = 4'd5;
        tick();
        in_latch = 1'b0; out_req = 1'b0;
`ifdef RAM_BYPASS_EN
        exp_collide = 16'hBE11;
`else
        exp_collide = 16'h0011;
`endif
        check_eq("col_valid", 32'(out_valid), 32'd1);
        check_eq("col_data",  32'(out_data),  32'(exp_collide));
        read_chk("col_after", 4'd5, 16'hBE11);

        // Different-address write and read in the same cycle are independent
        in_latch = 1'b1; in_addr = 4'd6; in_data = 16'hC0DE; in_be = 2'b11;
        out_req  = 1'b1; out_addr = 4'd7;
        tick();
        in_latch = 1'b0; out_req = 1'b0;
        check_eq("ind_data", 32'(out_data), 32'h0007);
        read_chk("ind_wr", 4'd6, 16'hC0DE);

        // be=0 write is a no-op
        write(4'd6, 16'hFFFF, 2'b00);
        read_chk("be0", 4'd6, 16'hC0DE);

        // Reset in the middle of the clear sequence, with traffic during busy
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_latch = 1'b1; in_addr = 4'd2; in_data = 16'h1111; in_be = 2'b11;
        out_req  = 1'b1; out_addr = 4'd2;
        count_busy(cnt, vseen);
        idle_inputs();
        check_eq("reclear_len",   32'(cnt),   32'd16);
        check_eq("busy_no_valid", 32'(vseen), 32'd0);
        for (int a = 0; a < 16; a++) read_chk("reclr_rd", AW'(a), CLRV);

        // Reset while a read is being returned
        out_req = 1'b1; out_addr = 4'd4;
        reset   = 1'b1;
        tick();
        out_req = 1'b0;
        check_eq("rst6_valid", 32'(out_valid), 32'd0);
        check_eq("rst6_data",  32'(out_data),  32'd0);
        check_eq("rst6_busy",  32'(busy),      32'd1);
        reset = 1'b0;
        count_busy(cnt, vseen);
        check_eq("rst6_clear_len", 32'(cnt), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ram_sync_be

`default_nettype wire
